input_port_fifo: RTL and testbench
==================================

Name: input_port_fifo

Overview:
- Receive side of the router-to-router link driven by a neighbour's crossbar output (dataout/validout pair).
- Buffers incoming flits in a first-word-fall-through FIFO and presents the head flit to the local route/arbitration logic.
- Returns one credit per consumed flit to the upstream router.
- Tracks packet framing (header/body/tail) and flags protocol and overflow violations.

Parameters:
DATA_WIDTH, 32, flit width; bits [DATA_WIDTH-1:DATA_WIDTH-3] carry flit type
DEPTH, 4, FIFO entries; power of two, at least 2
PTR_W, 2, log2(DEPTH)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
datain  input  DATA_WIDTH  flit from upstream crossbar dataout
validin  input  1  flit valid, from upstream crossbar validout
rd_en  input  1  local consumer pops the head flit
dataout  output  DATA_WIDTH  head flit (FWFT); 0 when empty
validout  output  1  FIFO non-empty
count  output  PTR_W+1  current occupancy, 0..DEPTH
credit_out  output  1  one-cycle pulse per flit popped
overflow_err  output  1  sticky: flit arrived while full and no pop
proto_err  output  1  sticky: framing violation

Behaviour:
- Reset (async, rst=1) forces: wr_ptr=0, rd_ptr=0, count=0, credit_out=0, overflow_err=0, proto_err=0, framing FSM=IDLE. validout=0 and dataout=0 follow combinationally. Storage contents are not reset.
- Flit types (top 3 bits):
  - 3'b001 HEAD
  - 3'b010 BODY
  - 3'b100 TAIL
  - 3'b101 HEAD+TAIL, a single-flit packet
  - any other code is illegal
- Write: on a clk edge with validin=1 and (count<DEPTH, or count==DEPTH with a pop in the same cycle), datain is stored at wr_ptr and wr_ptr increments modulo DEPTH.
- Overflow: validin=1 with count==DEPTH and no pop drops the flit and sets overflow_err. No other state changes.
- Pop: on a clk edge with rd_en=1 and count>0, rd_ptr increments modulo DEPTH and credit_out=1 in the next cycle. rd_en with count==0 is ignored: no credit, no error.
- Count update per cycle: +1 on write only, -1 on pop only, unchanged when both or neither occur.
- Simultaneous write and pop when empty: the popped entry does not exist, so the pop is ignored. The write is accepted and count becomes 1.
- Read latency: dataout = mem[rd_ptr] combinationally. A flit written at edge N is visible on dataout after edge N (zero-cycle fall-through from storage).
- credit_out is registered. Back-to-back pops produce a continuous high, one credit per cycle.
- Framing FSM, advanced only on accepted writes (dropped flits are ignored):
  - IDLE: HEAD goes to IN_PKT. HEAD+TAIL stays in IDLE. BODY, TAIL or an illegal code sets proto_err and stays in IDLE.
  - IN_PKT: BODY stays in IN_PKT. TAIL goes to IDLE. HEAD or HEAD+TAIL sets proto_err and stays in IN_PKT. An illegal code sets proto_err.
  - A flit that triggers proto_err is still stored. The error is a monitor only and never blocks data.
- Sticky errors clear only on rst.
- Reset mid-packet or mid-burst: all state returns to reset values immediately and in-flight flits are lost. The upstream credit counter is reset by the same rst.

Decomposition:
- Shared parameters/defines file holds DATA_WIDTH, the flit-type codes (HEAD/BODY/TAIL/HEAD_TAIL), the flit-type bit positions and the FSM state encodings IDLE/IN_PKT.
- One natural sub-module: flit_frame_checker (framing FSM plus proto_err), instantiated beside the FIFO datapath. It takes the accepted-write strobe and the type field.

Test Plan:
- Reset then write HEAD 0x2000_00AA, BODY 0x4000_0001, TAIL 0x8000_0002 with rd_en=0 -> count=3, dataout=0x2000_00AA, validout=1, proto_err=0.
- Fill 4 flits, then one more with rd_en=0 -> count stays 4, 5th flit dropped, overflow_err=1. Subsequent pops return the first 4 in order.
- At count=4, validin=1 and rd_en=1 together -> count stays 4, new flit accepted, credit_out=1 next cycle, overflow_err=0.
- Pop 4 consecutive cycles from full -> credit_out high for exactly 4 cycles starting one cycle after the first pop; count=0, validout=0, dataout=0. A 5th rd_en gives no credit.
- Write BODY 0x4000_0005 in IDLE -> proto_err=1, flit stored (count=1). Then HEAD, HEAD -> proto_err stays 1 and FSM remains IN_PKT.
- Assert rst asynchronously (between edges) with count=3 mid-packet -> count, validout, credit_out and errors go to 0 immediately. After release, a HEAD+TAIL flit 0xA000_0007 is accepted with no proto_err.

Source files
------------

// File: rtl/input_port_fifo_pkg.sv
// Shared definitions for the router input port: flit-type codes, field
// geometry and the framing-checker state encoding.
package input_port_fifo_pkg;

  localparam int FLIT_DATA_WIDTH = 32;
  localparam int FT_W            = 3;

  localparam logic [FT_W-1:0] FT_HEAD      = 3'b001;
  localparam logic [FT_W-1:0] FT_BODY      = 3'b010;
  localparam logic [FT_W-1:0] FT_TAIL      = 3'b100;
  localparam logic [FT_W-1:0] FT_HEAD_TAIL = 3'b101;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } frame_state_e;

endpackage

// File: rtl/input_port_fifo_flit_frame_checker.sv
// Packet framing monitor: follows header/body/tail order on accepted writes
// and raises a sticky proto_err on any violation. It never blocks data.
module flit_frame_checker
  import input_port_fifo_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_accept,
  input  logic [FT_W-1:0] flit_type,
  output logic            proto_err
);

  frame_state_e state_q, state_d;
  logic         err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    if (wr_accept) begin
      case (state_q)
        ST_IDLE: begin
          if (flit_type == FT_HEAD)           state_d = ST_IN_PKT;
          else if (flit_type != FT_HEAD_TAIL) err_d   = 1'b1;
        end
        ST_IN_PKT: begin
          // A stray header inside a packet is flagged but the packet stays open.
          if (flit_type == FT_TAIL)           state_d = ST_IDLE;
          else if (flit_type != FT_BODY)      err_d   = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign proto_err = err_q;

endmodule

// File: rtl/input_port_fifo.sv
// Router input port: FWFT flit FIFO with per-pop credit return, overflow
// detection and a packet-framing monitor.
module input_port_fifo
  import input_port_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FLIT_DATA_WIDTH,
  parameter int DEPTH      = 4,
  parameter int PTR_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] datain,
  input  logic                  validin,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dataout,
  output logic                  validout,
  output logic [PTR_W:0]        count,
  output logic                  credit_out,
  output logic                  overflow_err,
  output logic                  proto_err
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        count_q, count_d;
  logic                  credit_q, credit_d;
  logic                  ovf_q, ovf_d;

  logic full, empty, pop, wr, drop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  // A pop at full frees the slot the same-cycle write lands in.
  assign pop   = rd_en & ~empty;
  assign wr    = validin & (~full | pop);
  assign drop  = validin & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    credit_d = pop;
    ovf_d    = ovf_q | drop;
    if (wr)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (wr && !pop)      count_d = count_q + (PTR_W+1)'(1);
    else if (pop && !wr) count_d = count_q - (PTR_W+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      credit_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      credit_q <= credit_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= datain;
  end

  flit_frame_checker u_frame (
    .clk       (clk),
    .rst       (rst),
    .wr_accept (wr),
    .flit_type (datain[DATA_WIDTH-1 -: FT_W]),
    .proto_err (proto_err)
  );

  assign dataout      = empty ? '0 : mem_q[rd_ptr_q];
  assign validout     = ~empty;
  assign count        = count_q;
  assign credit_out   = credit_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_input_port_fifo.sv
// Self-checking bench for input_port_fifo: table vectors, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_input_port_fifo;
  import input_port_fifo_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] datain = '0;
  logic        validin = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] dataout;
  logic        validout;
  logic [2:0]  count;
  logic        credit_out, overflow_err, proto_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mq[$];
  bit m_inpkt, m_ovf, m_proto, m_credit;

  input_port_fifo #(.DATA_WIDTH(32), .DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .datain(datain), .validin(validin), .rd_en(rd_en),
    .dataout(dataout), .validout(validout), .count(count),
    .credit_out(credit_out), .overflow_err(overflow_err), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        r;
    logic [2:0]  cnt;
    logic [31:0] dout;
    logic        vo, cr, ovf, pe;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_inpkt = 0; m_ovf = 0; m_proto = 0; m_credit = 0;
  endtask

  task automatic model_frame(input logic [2:0] t);
    if (!m_inpkt) begin
      if (t == 3'b001) m_inpkt = 1;
      else if (t != 3'b101) m_proto = 1;
    end else begin
      if (t == 3'b100) m_inpkt = 0;
      else if (t != 3'b010) m_proto = 1;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".count"},    32'(count),    32'(mq.size()));
    chk({tag, ".dataout"},  dataout,       (mq.size() > 0) ? mq[0] : 32'h0);
    chk({tag, ".validout"}, 32'(validout), 32'(mq.size() > 0));
    chk({tag, ".credit"},   32'(credit_out), 32'(m_credit));
    chk({tag, ".ovf"},      32'(overflow_err), 32'(m_ovf));
    chk({tag, ".proto"},    32'(proto_err), 32'(m_proto));
  endtask

  // One clock: drive inputs, advance model, compare #1 after the edge.
  task automatic step(input logic v, input logic [31:0] d, input logic r, input string tag);
    bit pop, acc;
    pop = r && (mq.size() > 0);
    acc = v && ((mq.size() < DEPTH) || pop);
    validin = v; datain = d; rd_en = r;
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (acc) begin
      mq.push_back(d);
      model_frame(d[31:29]);
    end
    if (v && !acc) m_ovf = 1;
    m_credit = pop;
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    validin = 0; rd_en = 0; datain = '0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_clear();
    check_model("reset");
  endtask

  function automatic logic [31:0] rand_flit();
    int unsigned k;
    logic [2:0] t;
    k = $urandom_range(0, 9);
    if (k < 3)      t = 3'b001;
    else if (k < 6) t = 3'b010;
    else if (k < 8) t = 3'b100;
    else if (k < 9) t = 3'b101;
    else            t = 3'($urandom_range(0, 1) ? 3'b000 : 3'b111);
    return {t, 29'($urandom)};
  endfunction

  initial begin
    tbl[0]  = '{1'b1, 32'h2000_00AA, 1'b0, 3'd1, 32'h2000_00AA, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 32'h4000_0001, 1'b0, 3'd2, 32'h2000_00AA, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 32'h8000_0002, 1'b0, 3'd3, 32'h2000_00AA, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 32'h2000_0010, 1'b0, 3'd4, 32'h2000_00AA, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 32'h4000_0011, 1'b0, 3'd4, 32'h2000_00AA, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 32'h8000_0012, 1'b1, 3'd4, 32'h4000_0001, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 32'h0,         1'b1, 3'd3, 32'h8000_0002, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 32'h0,         1'b1, 3'd2, 32'h2000_0010, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 32'h0,         1'b1, 3'd1, 32'h8000_0012, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 32'h0,         1'b1, 3'd0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 32'h0,         1'b1, 3'd0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 32'h0,         1'b0, 3'd0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 32'h4000_0005, 1'b0, 3'd1, 32'h4000_0005, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{1'b1, 32'h2000_0020, 1'b0, 3'd2, 32'h4000_0005, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[14] = '{1'b1, 32'h2000_0021, 1'b0, 3'd3, 32'h4000_0005, 1'b1, 1'b0, 1'b1, 1'b1};

    do_reset();
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.validout", 32'(validout), 32'd0);
    chk("rst.dataout", dataout, 32'd0);

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].r, $sformatf("vec%0d", i));
      chk($sformatf("tbl%0d.count", i),  32'(count),        32'(tbl[i].cnt));
      chk($sformatf("tbl%0d.dout", i),   dataout,           tbl[i].dout);
      chk($sformatf("tbl%0d.valid", i),  32'(validout),     32'(tbl[i].vo));
      chk($sformatf("tbl%0d.credit", i), 32'(credit_out),   32'(tbl[i].cr));
      chk($sformatf("tbl%0d.ovf", i),    32'(overflow_err), 32'(tbl[i].ovf));
      chk($sformatf("tbl%0d.proto", i),  32'(proto_err),    32'(tbl[i].pe));
    end
    chk("fsm_in_pkt", 32'(dut.u_frame.state_q), 32'(ST_IN_PKT));

    // Simultaneous write and pop at full, then drain with credit pulses.
    do_reset();
    step(1, 32'h2000_0100, 0, "full.w0");
    step(1, 32'h4000_0101, 0, "full.w1");
    step(1, 32'h4000_0102, 0, "full.w2");
    step(1, 32'h4000_0103, 0, "full.w3");
    step(1, 32'h8000_0104, 1, "full.wr");
    chk("full.wr.count", 32'(count), 32'd4);
    chk("full.wr.credit", 32'(credit_out), 32'd1);
    chk("full.wr.ovf", 32'(overflow_err), 32'd0);
    chk("full.wr.dout", dataout, 32'h4000_0101);
    for (int i = 0; i < 4; i++) begin
      step(0, 32'h0, 1, $sformatf("drain%0d", i));
      chk($sformatf("drain%0d.credit", i), 32'(credit_out), 32'd1);
    end
    chk("drain.count", 32'(count), 32'd0);
    chk("drain.valid", 32'(validout), 32'd0);
    chk("drain.dout", dataout, 32'h0);
    step(0, 32'h0, 1, "drain.extra");
    chk("drain.extra.credit", 32'(credit_out), 32'd0);
    step(1, 32'hA000_0200, 1, "empty.wr");
    chk("empty.wr.count", 32'(count), 32'd1);
    chk("empty.wr.credit", 32'(credit_out), 32'd0);

    // Asynchronous reset mid-packet with errors and a credit pending.
    do_reset();
    step(1, 32'h4000_0300, 0, "ar.body");
    step(1, 32'h2000_0301, 0, "ar.head");
    step(1, 32'h4000_0302, 0, "ar.b1");
    step(1, 32'h4000_0303, 0, "ar.b2");
    step(1, 32'h4000_0304, 0, "ar.ovf");
    step(0, 32'h0, 1, "ar.pop");
    chk("ar.pre.count", 32'(count), 32'd3);
    chk("ar.pre.credit", 32'(credit_out), 32'd1);
    validin = 0; rd_en = 0;
    #2 rst = 1;
    #1;
    chk("ar.count", 32'(count), 32'd0);
    chk("ar.valid", 32'(validout), 32'd0);
    chk("ar.dout", dataout, 32'h0);
    chk("ar.credit", 32'(credit_out), 32'd0);
    chk("ar.ovf", 32'(overflow_err), 32'd0);
    chk("ar.proto", 32'(proto_err), 32'd0);
    model_clear();
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    step(1, 32'hA000_0007, 0, "ar.ht");
    chk("ar.ht.count", 32'(count), 32'd1);
    chk("ar.ht.dout", dataout, 32'hA000_0007);
    chk("ar.ht.proto", 32'(proto_err), 32'd0);

    // Randomized traffic against the model, with periodic resets.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i % 80 == 79) do_reset();
      step(1'($urandom_range(0, 99) < 60), rand_flit(),
           1'($urandom_range(0, 99) < 50), $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
